truth_table_sweeper: RTL and testbench

Sequential companion to the switch-to-LED truth-table logic: it drives every 4-bit input combination into a combinational function-under-test and samples the function's four outputs after each one. It assembles four 16-bit truth tables (LUT INIT-style words), one per output. It sits between a start button/controller and the combinational block on the board, and makes each LED function self-characterising for bring-up and regression.

---
 rtl/truth_table_pkg.sv | 17 +
 rtl/truth_table_sweeper.sv | 109 ++++++++++
 tb/tb_truth_table_sweeper.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/truth_table_pkg.sv
// Shared types and sizes for the truth-table sweeper.
package truth_table_pkg;

  localparam int unsigned N_INPUTS  = 4;
  localparam int unsigned N_VECTORS = 16;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned CNT_W     = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE
  } state_e;

  typedef logic [N_VECTORS-1:0] table_t;

endpackage : truth_table_pkg

// File: rtl/truth_table_sweeper.sv
// Walks all 4-bit input vectors through a combinational block and captures
// one 16-bit truth table per response bit, published atomically at sweep end.
module truth_table_sweeper
  import truth_table_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Start,
  output logic                o_Busy,
  output logic                o_Done,
  output logic [N_INPUTS-1:0] o_Stim,
  input  logic [N_INPUTS-1:0] i_Resp,
  output table_t              o_Table_1,
  output table_t              o_Table_2,
  output table_t              o_Table_3,
  output table_t              o_Table_4
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_VECTORS - 1);

  state_e                     state_q, state_d;
  logic   [IDX_W-1:0]         index_q, index_d;
  logic   [CNT_W-1:0]         cnt_q, cnt_d;
  table_t [N_INPUTS-1:0]      shadow_q, shadow_d;
  table_t [N_INPUTS-1:0]      tables_q, tables_d;
  logic                       busy_d;
  logic                       done_d;
  logic   [N_INPUTS-1:0]      stim_d;

  // State and datapath registers
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q  <= IDLE;
      index_q  <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      tables_q <= '0;
      o_Busy   <= 1'b0;
      o_Done   <= 1'b0;
      o_Stim   <= '0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      tables_q <= tables_d;
      o_Busy   <= busy_d;
      o_Done   <= done_d;
      o_Stim   <= stim_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    tables_d = tables_q;
    done_d   = 1'b0;
    busy_d   = 1'b0;
    stim_d   = '0;

    unique case (state_q)
      IDLE: begin
        if (i_Start) begin
          index_d = '0;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end
      SAMPLE: begin
        for (int unsigned n = 0; n < N_INPUTS; n++) begin
          shadow_d[n][index_q] = i_Resp[n];
        end
        // Publish includes the bit captured on this very edge
        if (index_q == LAST_IDX) begin
          tables_d = shadow_d;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          index_d = IDX_W'(index_q + 1'b1);
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    stim_d = busy_d ? N_INPUTS'(index_d) : '0;
  end

  assign o_Table_1 = tables_q[0];
  assign o_Table_2 = tables_q[1];
  assign o_Table_3 = tables_q[2];
  assign o_Table_4 = tables_q[3];

endmodule : truth_table_sweeper

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: expected tables/latency queued at start, checked at o_Done.
module tb_truth_table_sweeper;

  localparam logic [63:0] EXP_TBL  = 64'h8000_30F0_FFA0_8888;
  localparam logic [63:0] ONES_TBL = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        dsel;
  logic        const_mode;

  logic        busy_a, done_a, busy_b, done_b;
  logic [3:0]  stim_a, stim_b, resp_a, resp_b;
  logic [15:0] ta1, ta2, ta3, ta4, tb1, tb2, tb3, tb4;

  logic        obs_busy, obs_done;
  logic [3:0]  obs_stim;
  logic [63:0] obs_tables;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] last_tbl [2];
  logic [63:0] exp_q [$];
  int          lat_q [$];

  always #5 clk = ~clk;

  function automatic logic [3:0] fut(input logic [3:0] s, input logic ones);
    logic [3:0] r;
    if (ones) return 4'hF;
    r[0] = s[0] & s[1];
    r[1] = (s[0] & s[2]) | s[3];
    r[2] = !(s[1] & s[3]) & s[2];
    r[3] = &s;
    return r;
  endfunction

  assign resp_a = fut(stim_a, const_mode);
  assign resp_b = fut(stim_b, const_mode);

  assign obs_busy   = dsel ? busy_b : busy_a;
  assign obs_done   = dsel ? done_b : done_a;
  assign obs_stim   = dsel ? stim_b : stim_a;
  assign obs_tables = dsel ? {tb4, tb3, tb2, tb1} : {ta4, ta3, ta2, ta1};

  truth_table_sweeper #(.SETTLE_CYCLES(2)) dut_a (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start & ~dsel),
    .o_Busy(busy_a), .o_Done(done_a), .o_Stim(stim_a), .i_Resp(resp_a),
    .o_Table_1(ta1), .o_Table_2(ta2), .o_Table_3(ta3), .o_Table_4(ta4)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(1)) dut_b (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start & dsel),
    .o_Busy(busy_b), .o_Done(done_b), .o_Stim(stim_b), .i_Resp(resp_b),
    .o_Table_1(tb1), .o_Table_2(tb2), .o_Table_3(tb3), .o_Table_4(tb4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One sweep on the selected DUT; optional restart pulse and mid-sweep reset
  task automatic sweep(input logic sel, input int s, input int restart_at,
                       input int rst_at, input logic [63:0] exp_tbl);
    int lat;
    int cyc;
    int stim_bad;
    int busy_cnt;
    int hold_bad;
    int late_done;
    logic [63:0] e_tbl;
    int e_lat;
    lat = 16 * (s + 1);
    cyc = 0; stim_bad = 0; busy_cnt = 0; hold_bad = 0; late_done = 0;
    dsel = sel;
    exp_q.push_back(exp_tbl);
    lat_q.push_back(lat);
    start = 1'b1;
    step();
    start = 1'b0;
    while (!obs_done && cyc <= lat + 4) begin
      if (cyc < lat && obs_stim != 4'(cyc / (s + 1))) stim_bad++;
      if (obs_busy) busy_cnt++;
      if (obs_tables != last_tbl[sel]) hold_bad++;
      start = (cyc == restart_at);
      if (rst_at >= 0 && cyc == rst_at) break;
      step();
      cyc++;
    end
    start = 1'b0;

    if (rst_at >= 0) begin
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_mid_tables", obs_tables, 64'h0);
      check("rst_mid_busy", 64'(obs_busy), 64'h0);
      check("rst_mid_stim", 64'(obs_stim), 64'h0);
      for (int i = 0; i < lat; i++) begin
        if (obs_done) late_done++;
        step();
      end
      check("rst_mid_no_done", 64'(late_done), 64'h0);
      void'(exp_q.pop_front());
      void'(lat_q.pop_front());
      last_tbl[0] = 64'h0;
      last_tbl[1] = 64'h0;
      return;
    end

    e_tbl = exp_q.pop_front();
    e_lat = lat_q.pop_front();
    if (!obs_done) begin
      check("done_timeout", 64'(cyc), 64'(e_lat));
      return;
    end
    check("done_latency", 64'(cyc), 64'(e_lat));
    check("tables", obs_tables, e_tbl);
    check("stim_after_done", 64'(obs_stim), 64'h0);
    check("busy_after_done", 64'(obs_busy), 64'h0);
    check("stim_order_errs", 64'(stim_bad), 64'h0);
    check("busy_cycles", 64'(busy_cnt), 64'(e_lat));
    check("tables_held", 64'(hold_bad), 64'h0);
    step();
    check("done_one_cycle", 64'(obs_done), 64'h0);
    check("tables_stable", obs_tables, e_tbl);
    last_tbl[sel] = e_tbl;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dsel = 1'b0; const_mode = 1'b0;
    last_tbl[0] = 64'h0;
    last_tbl[1] = 64'h0;
    repeat (3) step();
    check("reset_tables_a", {ta4, ta3, ta2, ta1}, 64'h0);
    check("reset_tables_b", {tb4, tb3, tb2, tb1}, 64'h0);
    check("reset_ctl_a", {58'h0, busy_a, done_a, stim_a}, 64'h0);
    check("reset_ctl_b", {58'h0, busy_b, done_b, stim_b}, 64'h0);
    rst = 1'b0;
    repeat (2) step();

    sweep(1'b0, 2, -1, -1, EXP_TBL);
    repeat (3) step();
    sweep(1'b0, 2, 10, -1, EXP_TBL);
    repeat (3) step();
    sweep(1'b0, 2, -1, 20, EXP_TBL);
    repeat (3) step();
    sweep(1'b0, 2, -1, -1, EXP_TBL);
    repeat (3) step();
    const_mode = 1'b1;
    sweep(1'b0, 2, -1, -1, ONES_TBL);
    const_mode = 1'b0;
    repeat (3) step();
    sweep(1'b1, 1, -1, -1, EXP_TBL);
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_truth_table_sweeper
